rf_ctrl_sequencer: RTL and testbench

//  Initiator side of the register-file control interface. Accepts one request
//  per valid/ready handshake (CLR/LDI/INC/DEC/MOV/SWAP/ADDK on T1-T4/R1-R4).

---
 rtl/rf_ctrl_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_rf_ctrl_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_ctrl_sequencer.sv
// Register-file control sequencer: expands one accepted request into single-cycle RF write steps.
// Optional build macro RF_SAT_EN makes INC/DEC/ADDK saturate using RFOut2 feedback.
module rf_ctrl_sequencer #(
  parameter logic [2:0] SCRATCH = 3'b011,
  parameter int         REP_W   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [2:0] ReqOp,
  input  logic [2:0] ReqDst,
  input  logic [2:0] ReqSrc,
  input  logic [7:0] ReqImm,
  input  logic [7:0] RFOut2,
  output logic [1:0] FunSel,
  output logic [3:0] RSel,
  output logic [3:0] TSel,
  output logic [2:0] O1Sel,
  output logic [2:0] O2Sel,
  output logic       InSel,
  output logic [7:0] ImmOut,
  output logic       Done,
  output logic       Err
);

  // state | meaning
  // IDLE  | ReqReady high, waiting for a request
  // EXEC  | single write step (CLR/LDI/INC/DEC/MOV)
  // SW1   | SWAP: SCRATCH <= src
  // SW2   | SWAP: src <= dst
  // SW3   | SWAP: dst <= SCRATCH
  // REP   | ADDK: one INC step per cycle until the count expires
  // DONE  | Done pulse (Err if rejected)
  typedef enum logic [2:0] {IDLE, EXEC, SW1, SW2, SW3, REP, DONE} state_t;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_ADDK = 3'b110;

  localparam logic [1:0] FN_CLR  = 2'b00;
  localparam logic [1:0] FN_LOAD = 2'b01;
  localparam logic [1:0] FN_DEC  = 2'b10;
  localparam logic [1:0] FN_INC  = 2'b11;

  state_t           state, state_n;
  logic [2:0]       op_q, op_n;
  logic [2:0]       src_q, src_n;
  logic             err_q, err_qn;
  logic [REP_W-1:0] rep_cnt, rep_n;

  logic [1:0]       fun_n;
  logic [2:0]       addr_n;
  logic             wr_n;
  logic [2:0]       o1_n;
  logic [2:0]       dst_n;
  logic             in_n;
  logic [7:0]       imm_n;
  logic             done_n;
  logic             err_n;
  logic             rdy_n;
  logic [3:0]       rsel_n;
  logic [3:0]       tsel_n;

`ifndef RF_SAT_EN
  logic unused_rfout2;
  assign unused_rfout2 = ^RFOut2;
`endif

  function automatic logic [3:0] onehot(input logic [1:0] a);
    onehot = 4'b0001 << a;
  endfunction

  always_comb begin
    state_n = state;
    op_n    = op_q;
    src_n   = src_q;
    err_qn  = err_q;
    rep_n   = rep_cnt;
    dst_n   = O2Sel;
    imm_n   = ImmOut;
    fun_n   = FN_CLR;
    addr_n  = 3'b000;
    wr_n    = 1'b0;
    o1_n    = 3'b000;
    in_n    = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    rdy_n   = 1'b0;

    case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (ReqValid && ReqReady) begin
          rdy_n  = 1'b0;
          op_n   = ReqOp;
          src_n  = ReqSrc;
          dst_n  = ReqDst;
          imm_n  = ReqImm;
          err_qn = 1'b0;
          case (ReqOp)
            OP_CLR, OP_LDI, OP_INC, OP_DEC, OP_MOV: state_n = EXEC;
            OP_SWAP: begin
              if (ReqDst == SCRATCH || ReqSrc == SCRATCH) begin
                err_qn  = 1'b1;
                state_n = DONE;
              end else if (ReqDst == ReqSrc) begin
                state_n = DONE;
              end else begin
                state_n = SW1;
              end
            end
            OP_ADDK: begin
              rep_n   = ReqImm[REP_W-1:0];
              state_n = (ReqImm[REP_W-1:0] == '0) ? DONE : REP;
            end
            default: begin
              err_qn  = 1'b1;
              state_n = DONE;
            end
          endcase
        end
      end

      EXEC: begin
        wr_n    = 1'b1;
        addr_n  = O2Sel;
        state_n = DONE;
        case (op_q)
          OP_CLR: fun_n = FN_CLR;
          OP_LDI: fun_n = FN_LOAD;
          OP_INC: fun_n = FN_INC;
          OP_DEC: fun_n = FN_DEC;
          OP_MOV: begin
            fun_n = FN_LOAD;
            in_n  = 1'b1;
            o1_n  = src_q;
          end
          default: wr_n = 1'b0;
        endcase
`ifdef RF_SAT_EN
        if ((op_q == OP_INC && RFOut2 == 8'hFF) || (op_q == OP_DEC && RFOut2 == 8'h00)) begin
          wr_n  = 1'b0;
          fun_n = FN_CLR;
        end
`endif
      end

      SW1: begin
        wr_n    = 1'b1;
        fun_n   = FN_LOAD;
        in_n    = 1'b1;
        addr_n  = SCRATCH;
        o1_n    = src_q;
        state_n = SW2;
      end

      SW2: begin
        wr_n    = 1'b1;
        fun_n   = FN_LOAD;
        in_n    = 1'b1;
        addr_n  = src_q;
        o1_n    = O2Sel;
        state_n = SW3;
      end

      SW3: begin
        wr_n    = 1'b1;
        fun_n   = FN_LOAD;
        in_n    = 1'b1;
        addr_n  = O2Sel;
        o1_n    = SCRATCH;
        state_n = DONE;
      end

      REP: begin
        wr_n   = 1'b1;
        fun_n  = FN_INC;
        addr_n = O2Sel;
        rep_n  = rep_cnt - REP_W'(1);
        if (rep_cnt == REP_W'(1)) state_n = DONE;
`ifdef RF_SAT_EN
        // A saturated destination ends the repeat early without an error.
        if (RFOut2 == 8'hFF) begin
          wr_n    = 1'b0;
          fun_n   = FN_CLR;
          state_n = DONE;
        end
`endif
      end

      DONE: begin
        done_n  = 1'b1;
        err_n   = err_q;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    rsel_n = (wr_n &&  addr_n[2]) ? onehot(addr_n[1:0]) : 4'b0000;
    tsel_n = (wr_n && !addr_n[2]) ? onehot(addr_n[1:0]) : 4'b0000;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      op_q     <= 3'b000;
      src_q    <= 3'b000;
      err_q    <= 1'b0;
      rep_cnt  <= '0;
      FunSel   <= 2'b00;
      RSel     <= 4'b0000;
      TSel     <= 4'b0000;
      O1Sel    <= 3'b000;
      O2Sel    <= 3'b000;
      InSel    <= 1'b0;
      ImmOut   <= 8'h00;
      Done     <= 1'b0;
      Err      <= 1'b0;
      ReqReady <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      src_q    <= src_n;
      err_q    <= err_qn;
      rep_cnt  <= rep_n;
      FunSel   <= fun_n;
      RSel     <= rsel_n;
      TSel     <= tsel_n;
      O1Sel    <= o1_n;
      O2Sel    <= dst_n;
      InSel    <= in_n;
      ImmOut   <= imm_n;
      Done     <= done_n;
      Err      <= err_n;
      ReqReady <= rdy_n;
    end
  end

endmodule

// File: tb/tb_rf_ctrl_sequencer.sv
// Bench for rf_ctrl_sequencer: table of requests with explicit expected step traces,
// scoreboarded per cycle, plus hand-written SWAP, saturation and mid-operation reset sequences.
module tb_rf_ctrl_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       ReqValid = 1'b0;
  logic [2:0] ReqOp = '0, ReqDst = '0, ReqSrc = '0;
  logic [7:0] ReqImm = '0, RFOut2 = '0;
  logic       ReqReady;
  logic [1:0] FunSel;
  logic [3:0] RSel, TSel;
  logic [2:0] O1Sel, O2Sel;
  logic       InSel;
  logic [7:0] ImmOut;
  logic       Done, Err;

  always #5 Clock = ~Clock;

  rf_ctrl_sequencer dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqDst(ReqDst), .ReqSrc(ReqSrc), .ReqImm(ReqImm), .RFOut2(RFOut2),
    .FunSel(FunSel), .RSel(RSel), .TSel(TSel), .O1Sel(O1Sel), .O2Sel(O2Sel),
    .InSel(InSel), .ImmOut(ImmOut), .Done(Done), .Err(Err)
  );

  typedef struct packed {
    logic [1:0] fun;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [2:0] o1;
    logic [2:0] o2;
    logic       in_sel;
    logic [7:0] imm;
    logic       done;
    logic       err;
    logic       rdy;
  } obs_t;

  typedef struct {
    logic [2:0] op, dst, src;
    logic [7:0] imm, rf2;
    int         steps;
    logic [1:0] fun;
    logic [3:0] rsel, tsel;
    logic [2:0] o1;
    logic       in_sel;
    int         done_cyc;
    logic       err;
    string      name;
  } vec_t;

  obs_t       exp_q[$];
  vec_t       vecs[$];
  int         errors = 0;
  int         checks = 0;
  logic [2:0] cur_dst = '0;
  logic [7:0] cur_imm = '0;

  function automatic obs_t sample();
    obs_t s;
    s = '{fun: FunSel, rsel: RSel, tsel: TSel, o1: O1Sel, o2: O2Sel, in_sel: InSel,
          imm: ImmOut, done: Done, err: Err, rdy: ReqReady};
    return s;
  endfunction

  function automatic obs_t mk(logic [1:0] fun, logic [3:0] rsel, logic [3:0] tsel,
                              logic [2:0] o1, logic in_sel, logic done, logic err, logic rdy);
    obs_t s;
    s = '{fun: fun, rsel: rsel, tsel: tsel, o1: o1, o2: cur_dst, in_sel: in_sel,
          imm: cur_imm, done: done, err: err, rdy: rdy};
    return s;
  endfunction

  task automatic check(input string name, input int cyc, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc%0d: got=%h required=%h", name, cyc, got, exp);
    end
  endtask

  task automatic push_vec(input vec_t v);
    cur_dst = v.dst;
    cur_imm = v.imm;
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= v.steps; i++)
      exp_q.push_back(mk(v.fun, v.rsel, v.tsel, v.o1, v.in_sel, 1'b0, 1'b0, 1'b0));
    for (int i = v.steps + 1; i < v.done_cyc; i++)
      exp_q.push_back(mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, v.err, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // Called at a point 1ns after a rising edge; consumes every queued expectation.
  task automatic run_req(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [7:0] imm, input logic [7:0] rf2, input bit sat_switch,
                         input string name);
    bit   ok;
    int   n;
    obs_t e;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ReqReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge Clock); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s ready_wait: got=ReqReady 0 required=1 within 40 cycles", name);
      exp_q.delete();
      return;
    end
    @(negedge Clock);
    ReqValid = 1'b1; ReqOp = op; ReqDst = dst; ReqSrc = src; ReqImm = imm; RFOut2 = rf2;
    @(posedge Clock); #1;
    // Requests offered while busy must be ignored.
    ReqOp  = 3'($urandom_range(0, 7));
    ReqDst = 3'($urandom_range(0, 7));
    ReqSrc = 3'($urandom_range(0, 7));
    ReqImm = 8'($urandom_range(0, 255));
    n = 0;
    while (exp_q.size() > 0) begin
      if (n > 0) begin
        @(posedge Clock); #1;
      end
      e = exp_q.pop_front();
      check(name, n, sample(), e);
      if (sat_switch && n == 1) RFOut2 = 8'hFF;
      n++;
    end
    ReqValid = 1'b0;
  endtask

  initial begin
    vec_t v;
    //            op      dst     src     imm    rf2    st fun    rsel     tsel     o1    in  dc err name
    vecs.push_back('{3'd1, 3'b101, 3'd0,   8'h5A, 8'h10, 1, 2'b01, 4'b0010, 4'b0000, 3'd0, 0, 2, 0, "ldi_r2"});
    vecs.push_back('{3'd0, 3'b000, 3'd0,   8'hC3, 8'h10, 1, 2'b00, 4'b0000, 4'b0001, 3'd0, 0, 2, 0, "clr_t1"});
    vecs.push_back('{3'd2, 3'b111, 3'd0,   8'h01, 8'h10, 1, 2'b11, 4'b1000, 4'b0000, 3'd0, 0, 2, 0, "inc_r4"});
    vecs.push_back('{3'd3, 3'b010, 3'd0,   8'h02, 8'h10, 1, 2'b10, 4'b0000, 4'b0100, 3'd0, 0, 2, 0, "dec_t3"});
    vecs.push_back('{3'd4, 3'b110, 3'b011, 8'h00, 8'h10, 1, 2'b01, 4'b0100, 4'b0000, 3'd3, 1, 2, 0, "mov_r3_t4"});
    vecs.push_back('{3'd4, 3'b001, 3'b001, 8'h44, 8'h10, 1, 2'b01, 4'b0000, 4'b0010, 3'd1, 1, 2, 0, "mov_same"});
    vecs.push_back('{3'd6, 3'b000, 3'd0,   8'h03, 8'h10, 3, 2'b11, 4'b0000, 4'b0001, 3'd0, 0, 4, 0, "addk3"});
    vecs.push_back('{3'd6, 3'b000, 3'd0,   8'h00, 8'h10, 0, 2'b11, 4'b0000, 4'b0001, 3'd0, 0, 1, 0, "addk0"});
    vecs.push_back('{3'd6, 3'b100, 3'd0,   8'hF2, 8'h10, 2, 2'b11, 4'b0001, 4'b0000, 3'd0, 0, 3, 0, "addk_hi_bits"});
    vecs.push_back('{3'd6, 3'b011, 3'd0,   8'h0F, 8'h10, 15, 2'b11, 4'b0000, 4'b1000, 3'd0, 0, 16, 0, "addk15"});
    vecs.push_back('{3'd7, 3'b101, 3'b010, 8'h99, 8'h10, 0, 2'b00, 4'b0000, 4'b0000, 3'd0, 0, 1, 1, "op_rsvd"});
    vecs.push_back('{3'd5, 3'b100, 3'b011, 8'h00, 8'h10, 0, 2'b00, 4'b0000, 4'b0000, 3'd0, 0, 1, 1, "swap_src_scr"});
    vecs.push_back('{3'd5, 3'b011, 3'b100, 8'h00, 8'h10, 0, 2'b00, 4'b0000, 4'b0000, 3'd0, 0, 1, 1, "swap_dst_scr"});
    vecs.push_back('{3'd5, 3'b101, 3'b101, 8'h00, 8'h10, 0, 2'b00, 4'b0000, 4'b0000, 3'd0, 0, 1, 0, "swap_same"});
`ifdef RF_SAT_EN
    vecs.push_back('{3'd6, 3'b001, 3'd0,   8'h05, 8'hFF, 0, 2'b11, 4'b0000, 4'b0010, 3'd0, 0, 2, 0, "addk_sat_full"});
    vecs.push_back('{3'd2, 3'b111, 3'd0,   8'h00, 8'hFF, 0, 2'b11, 4'b1000, 4'b0000, 3'd0, 0, 2, 0, "inc_sat"});
`else
    vecs.push_back('{3'd6, 3'b001, 3'd0,   8'h05, 8'hFF, 5, 2'b11, 4'b0000, 4'b0010, 3'd0, 0, 6, 0, "addk_wrap"});
    vecs.push_back('{3'd2, 3'b111, 3'd0,   8'h00, 8'hFF, 1, 2'b11, 4'b1000, 4'b0000, 3'd0, 0, 2, 0, "inc_wrap"});
`endif

    #1;
    cur_dst = '0; cur_imm = '0;
    check("reset_state", 0, sample(), mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
    check("ready_after_reset", 1, sample(), mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));

    foreach (vecs[i]) begin
      v = vecs[i];
      push_vec(v);
      run_req(v.op, v.dst, v.src, v.imm, v.rf2, 1'b0, v.name);
    end

    cur_dst = 3'b100; cur_imm = 8'h77;
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0,   1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b01, 4'h0, 4'b1000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b01, 4'h0, 4'b0010, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b01, 4'b0001, 4'h0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0,   1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0,   1'b0, 1'b0, 1'b0, 1'b1));
    run_req(3'd5, 3'b100, 3'b001, 8'h77, 8'h10, 1'b0, "swap_r1_t2");

    cur_dst = 3'b010; cur_imm = 8'h00;
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0,   1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b01, 4'h0, 4'b1000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b01, 4'b0100, 4'h0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b01, 4'h0, 4'b0100, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0,   1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0,   1'b0, 1'b0, 1'b0, 1'b1));
    run_req(3'd5, 3'b010, 3'b110, 8'h00, 8'h10, 1'b0, "swap_t3_r3");

`ifdef RF_SAT_EN
    cur_dst = 3'b000; cur_imm = 8'h05;
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b11, 4'h0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, 4'h0, 4'h0,    3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    run_req(3'd6, 3'b000, 3'd0, 8'h05, 8'h00, 1'b1, "addk_sat_2nd");
`endif

    // Reset while the SWAP is in its second step.
    @(negedge Clock);
    ReqValid = 1'b1; ReqOp = 3'd5; ReqDst = 3'b100; ReqSrc = 3'b001; ReqImm = 8'h3C;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    cur_dst = 3'b100; cur_imm = 8'h3C;
    check("swap_sw2_before_reset", 2, sample(), mk(2'b01, 4'h0, 4'b0010, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0));
    #2 Reset = 1'b1;
    #1;
    cur_dst = '0; cur_imm = '0;
    check("reset_mid_swap", 0, sample(), mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge Clock); #1;
    check("reset_held", 0, sample(), mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge Clock);
    Reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge Clock); #1;
      check("after_mid_reset", c, sample(), mk(2'b00, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    end

    push_vec(vecs[0]);
    run_req(vecs[0].op, vecs[0].dst, vecs[0].src, vecs[0].imm, vecs[0].rf2, 1'b0, "ldi_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
